uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: oversampled majority-vote bit recovery, configurable data width,
//  oversampling ratio and stop bits, optional parity. Sits between the serial pin and the clock
//  logic's command decoder; delivers each received word with a 1-clk valid strobe.
// PARAMETERS
//  DATA_W     8  data bits per frame, LSB first (5..9)
//  CPB        8  clk cycles per bit; multiple of 4, >= 8
//  STOP_BITS  1  stop bits checked (1 or 2)
//  PARITY_ODD 0  0 = even, 1 = odd; used only with UART_RX_PARITY_EN
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  rx         in   1       asynchronous serial line, idle high
//  data       out  DATA_W  last good word; held until the next good word
//  data_valid out  1       1-clk pulse, data updated this cycle
//  frame_err  out  1       1-clk pulse, a stop bit sampled 0
//  parity_err out  1       1-clk pulse, parity mismatch (constant 0 without macro)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE, bit/cycle/vote counters=0, data=0, all pulses=0, busy=0; both
//    synchroniser flops set to 1 so reset release never looks like a start bit.
//  - rx passes a 2-flop synchroniser -> rx_s; all decisions use rx_s only.
//  - Bit cell = CPB clks, cnt 0..CPB-1. Votes taken when CPB/4 <= cnt <= 3*CPB/4-1 (CPB/2 samples).
//    Decision at cnt==CPB-1: bit=0 iff zeros > ones (a tie resolves to 1). Vote counters clear
//    after each decision.
//  - FSM: IDLE -> START on rx_s==0 (cnt=0). START: decision 1 -> IDLE (false start, no pulse);
//    decision 0 -> DATA. DATA: DATA_W cells shifted into a shadow register LSB first -> PARITY
//    (macro) or STOP. STOP: STOP_BITS cells; any stop bit 0 -> frame_err pulse, goto ERROR.
//    Last stop bit 1 -> IDLE in the same edge; data_valid=1 and data<=shadow unless parity failed.
//  - ERROR: stays until rx_s has been 1 for CPB consecutive clks (break recovery), then IDLE.
//  - Latency (8N1, CPB=8): let rx be low at edge k. START is entered at edge k+2. data_valid is
//    high in the cycle after edge k+82 = k+2+(1+DATA_W+STOP_BITS)*CPB.
//  - A new start bit is accepted on the first cycle back in IDLE. There is no gap requirement.
//  - On a bad frame, data and data_valid are untouched. Outputs are registered.
//  - Reset mid-frame aborts the frame with no pulse.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: one parity cell follows the data cells. Its computed parity is
//    XOR(data) ^ PARITY_ODD; on mismatch, the frame completes its stop check, and at that edge
//    parity_err pulses and data_valid is suppressed. If stop also fails, frame_err and
//    parity_err pulse together.
//  Undefined: no parity cell; parity_err tied 0; PARITY_ODD ignored.
// STRUCTURE
//  uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP, ERROR) and the width helper for
//    the cnt counter ($clog2(CPB)).
//  Sub-module uart_rx_sampler: synchroniser, cnt, vote counters; outputs bit_done and bit_val.
//    The top holds the FSM, shift register and outputs.
// TESTING
//  1 Defaults, send 0xA5 8N1 -> data=0xA5, data_valid 1 clk at k+82, busy low the same cycle.
//  2 Low glitch of 3 clks on an idle line -> START then IDLE, no pulse, data unchanged.
//  3 0x3C with stop bit forced 0, line high after 20 clks -> frame_err 1 clk, ERROR for >= CPB
//    clks, data keeps its old value; next 0x11 is received correctly.
//  4 Per bit, invert 1 of 4 vote samples, plus CPB/8 jitter -> 0x5A still received.
//  5 UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 -> valid; same frame with parity 0 ->
//    parity_err, no data_valid.
//  6 Assert reset during data bit 4 -> busy=0 next cycle, no pulses; a following 0xFF is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding and
// the width helper for the in-cell cycle counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        ERROR
    } uart_state_t;

    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-cell timing and majority vote: 2-flop synchroniser, per-cell cycle counter and
// zero/one vote counters sampled over the middle half of each cell.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CPB = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic run,
    output logic rx_s,
    output logic bit_done,
    output logic bit_val
);

    localparam int CW = cnt_width(CPB);
    localparam int VW = $clog2(CPB / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] VOTE_LO  = CW'(CPB / 4);
    localparam logic [CW-1:0] VOTE_HI  = CW'(3 * CPB / 4 - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [VW-1:0] zeros_reg;
    logic [VW-1:0] ones_reg;
    logic          in_window;

    assign in_window = (cnt_reg >= VOTE_LO) && (cnt_reg <= VOTE_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            // Preset to idle-high so leaving reset never looks like a start bit
            sync_reg  <= 2'b11;
            cnt_reg   <= '0;
            zeros_reg <= '0;
            ones_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], rx};
            if (!run || cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                zeros_reg <= '0;
                ones_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
                if (in_window) begin
                    if (sync_reg[1]) ones_reg  <= ones_reg + VW'(1);
                    else             zeros_reg <= zeros_reg + VW'(1);
                end
            end
        end
    end

    assign rx_s     = sync_reg[1];
    assign bit_done = run && (cnt_reg == CNT_LAST);
    // A tie favours 1, the idle level of the line
    assign bit_val  = !(zeros_reg > ones_reg);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver top: frame FSM, shift register and registered outputs.
// Optional parity cell enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CPB        = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int CW = cnt_width(CPB);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_rx_param: DATA_W must be 5..9");
    end
    if (CPB < 8 || (CPB % 4) != 0) begin : g_bad_cpb
        $error("uart_rx_param: CPB must be a multiple of 4 and >= 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end

    uart_state_t       state_reg;
    logic [3:0]        bit_idx_reg;
    logic [CW-1:0]     brk_cnt_reg;
    logic [DATA_W-1:0] shadow_reg;
    logic [DATA_W-1:0] data_reg;
    logic              data_valid_reg;
    logic              frame_err_reg;
    logic              rx_s;
    logic              bit_done;
    logic              bit_val;
    logic              run;

    assign run = (state_reg == START) || (state_reg == DATA) ||
                 (state_reg == PARITY) || (state_reg == STOP);

    uart_rx_sampler #(
        .CPB(CPB)
    ) u_sampler (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .run     (run),
        .rx_s    (rx_s),
        .bit_done(bit_done),
        .bit_val (bit_val)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad_reg;
    logic parity_err_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            bit_idx_reg    <= '0;
            brk_cnt_reg    <= '0;
            shadow_reg     <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    bit_idx_reg <= '0;
                    if (!rx_s) state_reg <= START;
                end
                START: begin
                    if (bit_done) begin
                        state_reg <= bit_val ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        par_bad_reg <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shadow_reg <= {bit_val, shadow_reg[DATA_W-1:1]};
                        if (bit_idx_reg == 4'(DATA_W - 1)) begin
                            bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                            state_reg   <= PARITY;
`else
                            state_reg   <= STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        par_bad_reg <= bit_val != ((^shadow_reg) ^ 1'(PARITY_ODD));
                        state_reg   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (!bit_val) begin
                            frame_err_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_reg <= par_bad_reg;
`endif
                            brk_cnt_reg   <= '0;
                            state_reg     <= ERROR;
                        end else if (bit_idx_reg == 4'(STOP_BITS - 1)) begin
                            state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_reg) begin
                                parity_err_reg <= 1'b1;
                            end else begin
                                data_valid_reg <= 1'b1;
                                data_reg       <= shadow_reg;
                            end
`else
                            data_valid_reg <= 1'b1;
                            data_reg       <= shadow_reg;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                        end
                    end
                end
                ERROR: begin
                    // Leave only after a full cell of continuous idle-high line
                    if (!rx_s) begin
                        brk_cnt_reg <= '0;
                    end else if (brk_cnt_reg == CW'(CPB - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        brk_cnt_reg <= brk_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

endmodule
